// File: rtl/pfb_pkg.sv
// Shared constants, pipeline tag type, FSM states and address helper for the
// polyphase-filter MAC sequencer.
package pfb_pkg;

  localparam int PFB_MAX_NFFT_LOG2 = 11;
  localparam int PFB_MIN_NFFT_LOG2 = 3;
  localparam int PFB_TAPS          = 24;
  localparam int PFB_MAC_LAT       = 28;

  // Sideband that travels alongside a sample through the MAC chain.
  typedef struct packed {
    logic                         valid;
    logic [PFB_MAX_NFFT_LOG2-1:0] phase;
    logic                         last;
  } pfb_tag_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } pfb_state_e;

  // Highest phase (nfft-1) for a given branch-count exponent.
  function automatic logic [PFB_MAX_NFFT_LOG2-1:0] pfb_last_phase(input logic [3:0] nfft_log2);
    logic [PFB_MAX_NFFT_LOG2-1:0] ones;
    ones = '1;
    return ~(ones << nfft_log2);
  endfunction

endpackage

// File: rtl/pfb_tag_pipe.sv
// Clock-enable gated shift register that delays the {valid, phase, last} tag
// by the MAC chain latency so it lines up with the last slice's P output.
module pfb_tag_pipe
  import pfb_pkg::*;
#(
  parameter int DEPTH = PFB_MAC_LAT
) (
  input  logic     clk,
  input  logic     sync_reset,
  input  logic     ce,
  input  pfb_tag_t din,
  output pfb_tag_t dout
);

  pfb_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      // NOTE: this is a flop chain, not a RAM, so every stage is cleared;
      // a stale valid bit must never survive a reset.
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (ce) begin
      // NOTE: non-blocking assignments make each stage take its predecessor's
      // pre-edge value, which is what turns this loop into a shift.
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/pfb_mac_ctrl.sv
// Polyphase-filter MAC chain sequencer: phase/address generation, chain clock
// enable and output tag realignment. Optional zero-fill drain: PFB_CTRL_FLUSH_EN.
module pfb_mac_ctrl
  import pfb_pkg::*;
#(
  parameter int MAX_NFFT_LOG2 = PFB_MAX_NFFT_LOG2,
  parameter int TAPS          = PFB_TAPS,
  parameter int MAC_LAT       = PFB_MAC_LAT,
  parameter int DW            = 32
) (
  input  logic                     clk,
  input  logic                     sync_reset,
  input  logic [3:0]               cfg_nfft_log2,
  input  logic                     cfg_valid,
  output logic                     cfg_err,
  input  logic                     s_tvalid,
  input  logic [DW-1:0]            s_tdata,
  output logic                     s_tready,
  output logic                     mac_ce,
  output logic [DW-1:0]            mac_din,
  output logic                     buf_we,
  output logic [MAX_NFFT_LOG2-1:0] buf_addr,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [MAX_NFFT_LOG2-1:0] m_tphase,
  output logic                     m_tlast,
  input  logic                     flush,
  output logic                     busy
);

  logic [MAX_NFFT_LOG2-1:0] phase;
  logic [3:0]               nfft_log2;
  logic [3:0]               pend_log2;
  logic                     pend_valid;
  logic                     fire;
  logic                     in_run;
  logic                     at_last;
  logic                     cfg_ok;
  logic                     apply_cfg;
  pfb_tag_t                 tag_in;
  pfb_tag_t                 tag_out;

  // A stalled output freezes the entire MAC chain, input side included.
  assign mac_ce  = ~(m_tvalid & ~m_tready);
  assign at_last = (phase == pfb_last_phase(nfft_log2));

`ifdef PFB_CTRL_FLUSH_EN
  localparam int FLUSH_W = $clog2(((2 ** MAX_NFFT_LOG2) * TAPS) + 1);

  pfb_state_e         state, state_nxt;
  logic [FLUSH_W-1:0] flush_cnt;
  logic [FLUSH_W-1:0] flush_len;

  // One zero per tap per branch pushes every real sample out of the chain.
  assign flush_len = FLUSH_W'(TAPS) << nfft_log2;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RUN) flush_cnt <= '0;
      else if (fire)       flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_nxt = state;
    in_run    = 1'b1;
    busy      = 1'b0;
    s_tready  = 1'b0;
    fire      = 1'b0;
    mac_din   = s_tdata;
    unique case (state)
      ST_RUN: begin
        s_tready = mac_ce;
        fire     = s_tvalid & mac_ce;
        if (flush) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        in_run  = 1'b0;
        busy    = 1'b1;
        fire    = mac_ce;
        mac_din = '0;
        if (mac_ce && (flush_cnt == flush_len - 1'b1)) state_nxt = ST_RUN;
      end
      default: ;
    endcase
  end
`else
  logic unused_flush;

  assign in_run       = 1'b1;
  assign busy         = 1'b0;
  assign s_tready     = mac_ce;
  assign fire         = s_tvalid & mac_ce;
  assign mac_din      = s_tdata;
  assign unused_flush = flush ^ TAPS[0];
`endif

  assign buf_we   = fire;
  assign buf_addr = phase;

  // A new branch count only takes effect on a frame boundary, never mid-frame.
  assign cfg_ok    = (cfg_nfft_log2 >= 4'(PFB_MIN_NFFT_LOG2)) &&
                     (cfg_nfft_log2 <= 4'(MAX_NFFT_LOG2));
  assign apply_cfg = pend_valid && in_run && (fire ? at_last : (phase == '0));

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      phase      <= '0;
      nfft_log2  <= 4'(MAX_NFFT_LOG2);
      pend_log2  <= 4'(MAX_NFFT_LOG2);
      pend_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      if (fire)      phase     <= at_last ? '0 : phase + 1'b1;
      if (apply_cfg) nfft_log2 <= pend_log2;
      if (cfg_valid && cfg_ok) begin
        pend_valid <= 1'b1;
        pend_log2  <= cfg_nfft_log2;
      end else if (apply_cfg) begin
        pend_valid <= 1'b0;
      end
      if (cfg_valid && !cfg_ok) cfg_err <= 1'b1;
    end
  end

  assign tag_in = '{valid: fire, phase: phase, last: at_last};

  pfb_tag_pipe #(
    .DEPTH(MAC_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .sync_reset(sync_reset),
    .ce        (mac_ce),
    .din       (tag_in),
    .dout      (tag_out)
  );

  assign m_tvalid = tag_out.valid;
  assign m_tphase = tag_out.phase;
  assign m_tlast  = tag_out.last;

endmodule
